// File: rtl/x_uart_tx.sv
// x_uart_tx: 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// The line is idle high, each frame is START, D0..D7 (LSB first) and STOP, and each bit lasts p_clk_hz/p_baud clocks.
module x_uart_tx #(
  parameter int p_clk_hz = 1200000,
  parameter int p_baud   = 115200,
  parameter int p_depth  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy
);
  localparam int lp_b  = p_clk_hz / p_baud;
  localparam int lp_tw = lp_b > 2 ? $clog2(lp_b) : 1;
  localparam int lp_aw = $clog2(p_depth);

  generate
    if (lp_b < 2 || p_depth < 2 || (p_depth & (p_depth - 1)) != 0) begin : g_bad_cfg
      $error("x_uart_tx: bit period under 2 clocks or FIFO depth not a power of 2");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7, S_STOP
  } state_t;

  logic [7:0]       r_mem [p_depth];
  logic [lp_aw:0]   r_wr, r_rd;
  state_t           r_state, w_state_n;
  logic [lp_tw-1:0] r_timer, w_timer_n;
  logic [7:0]       r_shift, w_shift_n;
  logic             r_tx, w_tx_n;
  logic             w_empty, w_full, w_push, w_pop, w_wrap, w_in_data;

  // The extra pointer bit tells a full FIFO (MSBs differ) from an empty one.
  assign w_empty   = r_wr == r_rd;
  assign w_full    = (r_wr[lp_aw] != r_rd[lp_aw]) && (r_wr[lp_aw-1:0] == r_rd[lp_aw-1:0]);
  assign w_wrap    = r_timer == lp_tw'(lp_b - 1);
  assign w_in_data = (r_state >= S_D0) && (r_state <= S_D7);
  assign w_push    = i_valid && !w_full;
  assign w_pop     = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_wrap));

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_timer_n = (r_state == S_IDLE || w_wrap) ? '0 : r_timer + 1'b1;
    if (w_pop) begin
      w_state_n = S_START;
      w_shift_n = r_mem[r_rd[lp_aw-1:0]];
    end else if (r_state == S_STOP && w_wrap) begin
      w_state_n = S_IDLE;
    end else if (r_state != S_IDLE && w_wrap) begin
      w_state_n = state_t'(r_state + 4'd1);
      w_shift_n = w_in_data ? {1'b0, r_shift[7:1]} : r_shift;
    end
    w_tx_n = (w_state_n == S_START) ? 1'b0 :
             (w_state_n >= S_D0 && w_state_n <= S_D7) ? w_shift_n[0] : 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_wr    <= r_wr + (lp_aw + 1)'(w_push);
      r_rd    <= r_rd + (lp_aw + 1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[lp_aw-1:0]] <= i_data;
  end

  assign o_tx    = r_tx;
  assign o_ready = !w_full;
  assign o_busy  = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_x_uart_tx.sv
// tb_x_uart_tx: checks x_uart_tx (B=10 and B=4 instances) against a frame-timing model and a line receiver.
module tb_x_uart_tx;
  localparam int dep = 4;
  int bp[2] = '{10, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] valid = '0;
  logic [1:0] ready, tx, busy;
  logic [7:0] data [2];

  always #5 clk = ~clk;

  x_uart_tx u0 (.i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .o_ready(ready[0]),
                .i_data(data[0]), .o_tx(tx[0]), .o_busy(busy[0]));
  x_uart_tx #(.p_clk_hz(1000000), .p_baud(250000)) u1 (.i_clk(clk), .i_rst(rst),
                .i_valid(valid[1]), .o_ready(ready[1]), .i_data(data[1]), .o_tx(tx[1]), .o_busy(busy[1]));

  int checks = 0, errors = 0, cyc = 0;
  int cnt[2], fstart[2], fend[2];
  logic [7:0] qd[2][dep];
  logic [7:0] fbyte[2];
  bit acc[2];
  logic [7:0] sent[2][512];
  logic [7:0] rcv[2][512];
  int ns[2], nr[2], rx_t[2];
  bit rx_act[2];
  logic [7:0] rx_sh[2];
  logic prev[2] = '{1'b1, 1'b1};
  int fall[2][2];

  typedef struct { logic [7:0] d; logic [9:0] line; } vec_t;
  vec_t vt[6];

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", n, got, exp, cyc);
    end
  endtask

  // Line level implied by the frame in flight: start bit, 8 data bits LSB first, stop bit.
  function automatic logic exp_tx(int i);
    int pos;
    if (cyc >= fend[i]) return 1'b1;
    pos = (cyc - fstart[i]) / bp[i];
    return pos == 0 ? 1'b0 : pos == 9 ? 1'b1 : fbyte[i][pos-1];
  endfunction

  task automatic model_edge(int i);
    int pre;
    pre = cnt[i];
    acc[i] = valid[i] && pre < dep;
    if (pre > 0 && cyc >= fend[i]) begin
      fbyte[i] = qd[i][0];
      for (int j = 0; j < dep - 1; j++) qd[i][j] = qd[i][j+1];
      cnt[i]--;
      fstart[i] = cyc;
      fend[i] = cyc + 10 * bp[i];
    end
    if (acc[i]) begin
      qd[i][cnt[i]] = data[i];
      cnt[i]++;
      if (ns[i] < 512) sent[i][ns[i]++] = data[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; fend[i] = 0; fstart[i] = 0; acc[i] = 0;
      ns[i] = nr[i]; rx_act[i] = 0;
    end
  endtask

  task automatic rx(int i);
    int b;
    b = bp[i];
    if (rx_act[i]) begin
      rx_t[i]++;
      if (rx_t[i] % b == b / 2 && rx_t[i] / b >= 1 && rx_t[i] / b <= 8)
        rx_sh[i] = {tx[i], rx_sh[i][7:1]};
      if (rx_t[i] == 9 * b + b / 2) begin
        chk($sformatf("rx_stop%0d", i), tx[i], 1);
        if (nr[i] < 512) rcv[i][nr[i]++] = rx_sh[i];
        rx_act[i] = 0;
      end
    end else if (prev[i] && !tx[i]) begin
      rx_act[i] = 1; rx_t[i] = 0;
      fall[i][0] = fall[i][1]; fall[i][1] = cyc;
    end
    prev[i] = tx[i];
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst) for (int i = 0; i < 2; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("tx%0d", i), tx[i], exp_tx(i));
      chk($sformatf("ready%0d", i), ready[i], cnt[i] < dep);
      chk($sformatf("busy%0d", i), busy[i], cyc < fend[i] || cnt[i] > 0);
      rx(i);
    end
  endtask

  task automatic push(int i, logic [7:0] d, output int k);
    valid[i] = 1'b1; data[i] = d;
    tick();
    valid[i] = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while ((cyc < fend[i] || cnt[i] > 0) && n < 3000) begin tick(); n++; end
    chk("idle_bound", n < 3000, 1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, base, acn, lows, a0, a1, n;
    logic [7:0] dv;
    data[0] = '0; data[1] = '0;
    vt[0] = '{8'h55, 10'b1010101010};
    vt[1] = '{8'h00, 10'b1000000000};
    vt[2] = '{8'hFF, 10'b1111111110};
    vt[3] = '{8'hA5, 10'b1101001010};
    vt[4] = '{8'h01, 10'b1000000010};
    vt[5] = '{8'h80, 10'b1100000000};
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    push(0, 8'h3C, k);
    chk("push_after_reset", busy[0], 1);
    for (int v = 0; v < 6; v++) begin
      wait_idle(0);
      push(0, vt[v].d, k);
      for (int j = 0; j < 10; j++) begin
        while (cyc < k + 1 + j * 10 + 5) tick();
        chk($sformatf("vec%0d_bit%0d", v, j), tx[0], vt[v].line[j]);
      end
      while (cyc < k + 100) tick();
      chk($sformatf("vec%0d_busy_stop", v), busy[0], 1);
      tick();
      chk($sformatf("vec%0d_busy_end", v), busy[0], 0);
    end
    wait_idle(0);
    push(0, 8'h00, k);
    push(0, 8'hFF, k);
    wait_idle(0);
    chk("b2b_gap", fall[0][1] - fall[0][0], 100);
    wait_idle(0);
    base = nr[0]; dv = 8'h01; k = -1; acn = 0;
    valid[0] = 1'b1; data[0] = dv;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (acc[0]) begin
        if (k < 0) k = cyc;
        acn++;
        if (dv < 8'h06) dv++;
        data[0] = dv;
      end
    end
    chk("full_ready_held", ready[0], 0);
    valid[0] = 1'b0;
    while (cyc < k + 100) tick();
    chk("full_ready_last", ready[0], 0);
    tick();
    chk("full_ready_free", ready[0], 1);
    wait_idle(0);
    chk("full_count", nr[0] - base, 5);
    for (int j = 0; j < 5; j++) chk($sformatf("full_order%0d", j), rcv[0][base+j], j + 1);
    push(0, 8'hA5, k);
    while (cyc < k + 1 + 40 + 3) tick();
    chk("d3_low", tx[0], 0);
    rst = 1'b1;
    #1;
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", ready[0], 1);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    lows = 0;
    repeat (150) begin tick(); if (!tx[0]) lows++; end
    chk("no_frame_after_reset", lows, 0);
    a0 = 0; a1 = 0; n = 0;
    while ((a0 < 256 || a1 < 64) && n < 60000) begin
      valid[0] = a0 < 256 && $urandom_range(3) != 0;
      valid[1] = a1 < 64 && $urandom_range(3) != 0;
      data[0] = 8'($urandom);
      data[1] = 8'($urandom);
      tick();
      if (acc[0]) a0++;
      if (acc[1]) a1++;
      n++;
    end
    chk("random_bound", n < 60000, 1);
    valid = '0;
    wait_idle(0);
    wait_idle(1);
    repeat (5) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rx_count%0d", i), nr[i], ns[i]);
      for (int j = 0; j < ns[i] && j < nr[i]; j++)
        chk($sformatf("rx%0d_byte%0d", i, j), rcv[i][j], sent[i][j]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
